// File: rtl/decoder_pkg.sv
// Shared definitions for the 3-to-8 decoder slice.
// Holds the datapath widths, the FIFO depth, the one-hot word type and
// the code-to-one-hot helper. The top (decoder3_8) and its output FIFO
// (decoder3_8_fifo) both use it.
package decoder_pkg;

  localparam int DEC_IN_W       = 3;
  localparam int DEC_OUT_W      = 8;
  localparam int DEC_FIFO_DEPTH = 2;
  localparam int DEC_CNT_W      = 8;

  typedef logic [DEC_OUT_W-1:0] onehot_t;

  function automatic onehot_t decode_onehot(input logic [DEC_IN_W-1:0] code);
    return onehot_t'(1) << code;
  endfunction

endpackage

// File: rtl/decoder3_8_fifo.sv
// Two-entry in-order FIFO holding decoded one-hot words.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push_i      - write wdata_i this cycle (dropped when full)
//   pop_i       - consume the head this cycle (ignored when empty)
//   wdata_i     - word to enqueue
//   rdata_o     - head word, 0 when empty
//   valid_o     - FIFO holds at least one word
//   full_o      - FIFO holds DEC_FIFO_DEPTH words
module decoder3_8_fifo
  import decoder_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  logic    pop_i,
  input  onehot_t wdata_i,
  output onehot_t rdata_o,
  output logic    valid_o,
  output logic    full_o
);

  localparam logic [1:0] FULL_OCC = 2'(DEC_FIFO_DEPTH);

  logic [1:0] occ_q, occ_d;
  onehot_t    head_q, head_d;
  onehot_t    tail_q, tail_d;
  logic       push_eff;
  logic       pop_eff;

  assign valid_o  = (occ_q != 2'd0);
  assign full_o   = (occ_q == FULL_OCC);
  assign rdata_o  = valid_o ? head_q : '0;
  assign push_eff = push_i && !full_o;
  assign pop_eff  = pop_i && valid_o;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case ({push_eff, pop_eff})
      2'b10: begin
        if (occ_q == 2'd0) head_d = wdata_i;
        else               tail_d = wdata_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        tail_d = '0;
        occ_d  = occ_q - 2'd1;
      end
      // Both only possible at occupancy 1: the old head leaves and the
      // new word takes its place.
      2'b11: head_d = wdata_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/decoder3_8.sv
// 3-to-8 one-hot decoder with valid/ready handshakes, a 2-entry output
// FIFO and a running count of enqueued words.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   en                  - allows new codes to be accepted (never blocks draining)
//   in_valid/in_ready   - input handshake; in_ready = en && FIFO not full
//   in[2:0]             - binary code
//   out_valid/out_ready - output handshake
//   out[7:0]            - one-hot word at FIFO head, 0 when empty
//   dec_cnt[7:0]        - wrapping count of enqueued words
// Optional build macro DECODER3_8_PARITY_EN adds in_par (odd parity over
// {in, in_par}) and par_err (one-cycle pulse when a code with bad parity
// is accepted; such codes are consumed but dropped).
module decoder3_8
  import decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DEC_IN_W-1:0]  in,
`ifdef DECODER3_8_PARITY_EN
  input  logic                 in_par,
  output logic                 par_err,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DEC_OUT_W-1:0] out,
  output logic [DEC_CNT_W-1:0] dec_cnt
);

  logic                 fifo_full;
  logic                 accept;
  logic                 par_ok;
  logic                 push;
  logic [DEC_CNT_W-1:0] cnt_q, cnt_d;
  onehot_t              word;
  onehot_t              head;

  // rst_n is folded in so the block never advertises readiness in reset.
  assign in_ready = rst_n && en && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign word     = decode_onehot(in);

`ifdef DECODER3_8_PARITY_EN
  logic par_err_q, par_err_d;

  assign par_ok    = ^{in, in_par};
  assign par_err_d = accept && !par_ok;
  assign par_err   = par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end
`else
  assign par_ok = 1'b1;
`endif

  assign push  = accept && par_ok;
  assign cnt_d = cnt_q + DEC_CNT_W'(push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign dec_cnt = cnt_q;

  decoder3_8_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (out_ready),
    .wdata_i (word),
    .rdata_o (head),
    .valid_o (out_valid),
    .full_o  (fifo_full)
  );

  assign out = head;

endmodule

// File: tb/tb_decoder3_8.sv
module tb_decoder3_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] in = 3'd0;
  logic       in_par = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out;
  logic [7:0] dec_cnt;
`ifdef DECODER3_8_PARITY_EN
  logic       par_err;
`endif

  always #5 clk = ~clk;

  decoder3_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
`ifdef DECODER3_8_PARITY_EN
    .in_par    (in_par),
    .par_err   (par_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .dec_cnt   (dec_cnt)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_cnt  = 8'd0;
  bit         exp_perr = 1'b0;
  bit         mon_pop  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // in_par value that makes {code, in_par} odd parity.
  function automatic bit good_par(input logic [2:0] code);
    return ((code[0] + code[1] + code[2]) % 2) == 0;
  endfunction

  // Drive one cycle of stimulus, check combinational/registered status
  // against the model, and record what the DUT must enqueue.
  task automatic cycle(input bit e, input bit iv, input logic [2:0] code,
                       input bit ordy, input bit par);
    bit acc;
    bit ok;
    @(negedge clk);
    en = e; in_valid = iv; in = code; out_ready = ordy; in_par = par;
    #2;
    chk("in_ready", in_ready, 32'(e && exp_q.size() < 2));
    chk("dec_cnt", dec_cnt, 32'(exp_cnt));
`ifdef DECODER3_8_PARITY_EN
    chk("par_err", par_err, 32'(exp_perr));
    ok = (par == good_par(code));
`else
    ok = 1'b1;
`endif
    acc = iv && e && (exp_q.size() < 2);
    @(posedge clk);
    #1;
    exp_perr = acc && !ok;
    if (acc && ok) begin
      exp_q.push_back(8'(2 ** code));
      exp_cnt = exp_cnt + 8'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt  = 8'd0;
    exp_perr = 1'b0;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_in_ready", in_ready, 32'd0);
    chk("rst_dec_cnt", dec_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares the presented head against the scoreboard and pops
  // whenever the downstream consumes it.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk("out_valid", out_valid, 32'(exp_q.size() != 0));
      chk("out", out, 32'(exp_q.size() != 0 ? exp_q[0] : 8'h00));
      mon_pop = (exp_q.size() != 0) && out_ready;
      @(posedge clk);
      #1;
      if (mon_pop) void'(exp_q.pop_front());
    end
  end

  initial begin
    do_reset();

    // Codes 0..7 streamed with the consumer always ready.
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 3'(k), 1'b1, good_par(3'(k)));
    chk("cnt_after_8", dec_cnt, 32'd8);
    cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);

    // Back-pressure: fill to 2, in_ready drops, then drain in order.
    cycle(1'b1, 1'b1, 3'd2, 1'b0, good_par(3'd2));
    cycle(1'b1, 1'b1, 3'd6, 1'b0, good_par(3'd6));
    cycle(1'b1, 1'b1, 3'd1, 1'b0, good_par(3'd1));
    chk("full_out_hold", out, 32'h04);
    repeat (3) cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);

    // Occupancy 1 with simultaneous accept and pop.
    cycle(1'b1, 1'b1, 3'd3, 1'b0, good_par(3'd3));
    cycle(1'b1, 1'b1, 3'd7, 1'b1, good_par(3'd7));
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("simul_head", out, 32'h80);
    cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    // Pop attempt on empty FIFO.
    cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);

    // Full queue with a pop: accept resumes the next cycle.
    cycle(1'b1, 1'b1, 3'd4, 1'b0, good_par(3'd4));
    cycle(1'b1, 1'b1, 3'd5, 1'b0, good_par(3'd5));
    cycle(1'b1, 1'b1, 3'd0, 1'b1, good_par(3'd0));
    cycle(1'b1, 1'b1, 3'd1, 1'b1, good_par(3'd1));
    repeat (3) cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);

    // en low blocks accepts but not draining.
    cycle(1'b1, 1'b1, 3'd2, 1'b0, good_par(3'd2));
    cycle(1'b1, 1'b1, 3'd3, 1'b0, good_par(3'd3));
    cycle(1'b0, 1'b1, 3'd4, 1'b0, good_par(3'd4));
    repeat (3) cycle(1'b0, 1'b1, 3'd4, 1'b1, good_par(3'd4));

    // 256 enqueues from reset wrap the counter back to 0.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      automatic logic [2:0] c = 3'($urandom_range(0, 7));
      cycle(1'b1, 1'b1, c, 1'b1, good_par(c));
    end
    chk("cnt_wrap", dec_cnt, 32'h00);
    cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);

    // Reset with two words queued: neither may appear afterwards.
    cycle(1'b1, 1'b1, 3'd5, 1'b0, good_par(3'd5));
    cycle(1'b1, 1'b1, 3'd6, 1'b0, good_par(3'd6));
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);

`ifdef DECODER3_8_PARITY_EN
    // Bad parity is consumed and dropped; good parity decodes.
    cycle(1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("par_good_out", out, 32'h08);
    cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      automatic logic [2:0] c = 3'($urandom_range(0, 7));
      automatic bit p = good_par(c) ^ ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, c,
                 $urandom_range(0, 2) != 0, p);
    end
    repeat (4) cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
